alu_result_fifo: RTL and testbench

//  Downstream stage of the 32-bit ALU. Captures each ALU result (O) with its

---
 rtl/alu_result_fifo.sv | 81 ++++++++
 tb/tb_alu_result_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - show-ahead result FIFO between the ALU and its consumer
// Optional push counter port total_cnt is enabled by defining ALU_RES_CNT_EN.
module alu_result_fifo #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_zero,
    output logic             out_neg,
`ifdef ALU_RES_CNT_EN
    output logic [15:0]      total_cnt,
`endif
    output logic [AW:0]      level
);

    localparam int EW = WIDTH + SEL_W + 2;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    assign in_ready  = (level != FULL_LVL);
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];

    // Outputs are zeroed when empty so stale storage never leaks to the consumer.
    assign out_result = out_valid ? head[EW-1 -: WIDTH]   : '0;
    assign out_sel    = out_valid ? head[SEL_W+1 -: SEL_W] : '0;
    assign out_zero   = out_valid ? head[1]               : 1'b0;
    assign out_neg    = out_valid ? head[0]               : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_result, in_sel, (in_result == '0), in_result[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef ALU_RES_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_cnt <= '0;
        end else if (push) begin
            total_cnt <= total_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - scoreboard bench for alu_result_fifo
module tb_alu_result_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_sel;
    logic        out_zero;
    logic        out_neg;
    logic [2:0]  level;
`ifdef ALU_RES_CNT_EN
    logic [15:0] total_cnt;
    logic [15:0] cnt_model;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  sel;
    } entry_t;

    entry_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_result_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`ifdef ALU_RES_CNT_EN
        .total_cnt  (total_cnt),
`endif
        .level      (level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then apply the edge to the model.
    task automatic step(input logic v, input logic [31:0] r, input logic [3:0] s, input logic rdy);
        entry_t e;
        bit push;
        bit pop;
        in_valid  = v;
        in_result = r;
        in_sel    = s;
        out_ready = rdy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(q.size() != 4));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("level", 64'(level), 64'(q.size()));
        if (q.size() > 0) begin
            e = q[0];
            chk("out_result", 64'(out_result), 64'(e.res));
            chk("out_sel", 64'(out_sel), 64'(e.sel));
            chk("out_zero", 64'(out_zero), 64'(e.res == 32'd0));
            chk("out_neg", 64'(out_neg), 64'(e.res[31]));
        end else begin
            chk("empty_result", 64'(out_result), 64'd0);
            chk("empty_flags", 64'({out_sel, out_zero, out_neg}), 64'd0);
        end
`ifdef ALU_RES_CNT_EN
        chk("total_cnt", 64'(total_cnt), 64'(cnt_model));
`endif
        push = v && (q.size() < 4);
        pop  = rdy && (q.size() > 0);
        if (pop) void'(q.pop_front());
        if (push) begin
            e.res = r;
            e.sel = s;
            q.push_back(e);
`ifdef ALU_RES_CNT_EN
            cnt_model = cnt_model + 16'd1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_sel = '0; out_ready = 1'b0;
`ifdef ALU_RES_CNT_EN
        cnt_model = 16'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset / idle
        step(1'b0, 32'd0, 4'd0, 1'b1);
        step(1'b0, 32'd0, 4'd0, 1'b0);

        // basic push, flags, pop
        step(1'b1, 32'd5, 4'd1, 1'b0);
        step(1'b1, 32'd0, 4'd0, 1'b0);
        step(1'b0, 32'd0, 4'd0, 1'b0);
        step(1'b0, 32'd0, 4'd0, 1'b1);
        step(1'b0, 32'd0, 4'd0, 1'b1);
        step(1'b0, 32'd0, 4'd0, 1'b0);

        // negative result
        step(1'b1, 32'hFFFF_FFFF, 4'd2, 1'b0);
        step(1'b0, 32'd0, 4'd0, 1'b1);
        step(1'b0, 32'd0, 4'd0, 1'b0);

        // fill, overflow attempt, drain, with pointer wrap
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 4'(i), 1'b0);
        step(1'b1, 32'd9, 4'd9, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 32'h8000_0000 + 32'(i), 4'(i + 3), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 4'd0, 1'b1);

        // steady-state push+pop at level 2
        step(1'b1, 32'd100, 4'd7, 1'b0);
        step(1'b1, 32'd101, 4'd8, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'd200 + 32'(i), 4'(i), 1'b1);
        step(1'b1, 32'd300, 4'd1, 1'b0);

        // async reset mid-stream at level 3
        rst = 1'b1;
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        q.delete();
`ifdef ALU_RES_CNT_EN
        chk("rst_total_cnt", 64'(total_cnt), 64'd0);
        cnt_model = 16'd0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 32'd0, 4'd0, 1'b1);
        step(1'b1, 32'd42, 4'd3, 1'b0);
        step(1'b0, 32'd0, 4'd0, 1'b1);
        step(1'b0, 32'd0, 4'd0, 1'b0);

`ifdef ALU_RES_CNT_EN
        // counter wrap: bring count to 16'hFFFF, then one more push
        step(1'b1, 32'd1, 4'd1, 1'b0);
        while (cnt_model != 16'hFFFF) step(1'b1, 32'(cnt_model), 4'd2, 1'b1);
        step(1'b1, 32'd7, 4'd3, 1'b1);
        chk("cnt_wrap", 64'(total_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
